cordic_scheduler: RTL
=====================

CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 Parameter WIDTH, default 32, component width of I and Q and of magnitude and phase.
REQ-002 Parameter DEPTH, default 16, CORDIC iteration count; shared core latency is DEPTH+1 advancing cycles.
REQ-003 Parameter CHANNELS, default 4, number of requesters, 2..16.
REQ-004 Parameter TAGS, default 32, tag FIFO depth, power of two, at least DEPTH+2.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  CHANNELS  per-channel arbitration enable mask.
REQ-008 s_valid  in  CHANNELS  per-channel sample valid.
REQ-009 s_ready  out  CHANNELS  per-channel sample accept.
REQ-010 s_data  in  CHANNELS*2*WIDTH  channel k is slice k, with Q in the upper half and I in the lower half.
REQ-011 c_s_valid / c_s_ready / c_s_data  out / in / out  1 / 1 / 2*WIDTH  issue port to the shared cartesian-to-polar core.
REQ-012 c_m_valid / c_m_ready / c_m_data  in / out / in  1 / 1 / 2*WIDTH  result port from the core, with magnitude in the upper half and phase in the lower half.
REQ-013 m_valid / m_ready / m_data  out / in / out  1 / 1 / 2*WIDTH  tagged result stream.
REQ-014 m_dest  out  clog2(CHANNELS)  originating channel of m_data.
REQ-015 inflight  out  clog2(TAGS)+1  count of issued samples not yet delivered.
REQ-016 err  out  1  sticky protocol error flag.

Function
REQ-017 A channel is eligible when s_valid[k] and enable[k] are both high.
REQ-018 Grant is the first eligible channel, searching upward from the round-robin pointer rr and wrapping modulo CHANNELS.
REQ-019 c_s_valid is high when any channel is eligible and the tag FIFO is not full.
REQ-020 c_s_data equals the granted channel's s_data slice; when c_s_valid is low, c_s_data is don't-care.
REQ-021 Issue occurs when c_s_valid and c_s_ready are both high.
REQ-022 On issue, s_ready is high only for the granted channel; otherwise all s_ready bits are low.
REQ-023 On issue, the granted channel index is pushed to the tag FIFO and rr becomes grant+1 modulo CHANNELS.
REQ-024 Without an issue, rr holds its value.
REQ-025 A channel whose enable bit is low is never granted, even with s_valid high; its s_ready stays low.
REQ-026 Dropping an enable bit does not affect that channel's already-issued samples.
REQ-027 Result path is combinational pass-through: m_valid = c_m_valid, m_data = c_m_data, c_m_ready = m_ready.
REQ-028 m_dest equals the tag FIFO head; when the FIFO is empty, m_dest is 0.
REQ-029 A delivery is m_valid and m_ready both high; each delivery pops one tag.
REQ-030 Tags are delivered strictly in issue order; the core preserves order and has fixed latency.
REQ-031 A push and a pop in the same cycle leave the FIFO occupancy unchanged and are both performed.
REQ-032 inflight increments on issue only, decrements on delivery only, and holds when both or neither occur.
REQ-033 When the tag FIFO holds TAGS entries, c_s_valid is forced low; issue resumes in the cycle after the first pop.
REQ-034 A core result (c_m_valid high) while the tag FIFO is empty sets err; err stays set until reset.
REQ-035 The result accompanying that error is still passed through, with m_dest = 0, and does not pop a tag.
REQ-036 Backpressure: m_ready low stalls the core, which deasserts c_s_ready; no issue occurs and all state holds.
REQ-037 Stall duration is unbounded with no loss or duplication of samples.

Reset
REQ-038 While reset is high at a clock edge: rr = 0, the tag FIFO is emptied, inflight = 0, and err = 0.
REQ-039 In the cycle following reset, all s_ready bits are low and c_s_valid is low.
REQ-040 Reset mid-operation discards all outstanding tags; the core is reset from the same reset signal.
REQ-041 Issue may occur in the first cycle after reset deasserts.

Verification
REQ-042 Channel 2 only, I=1000, Q=0, m_ready=1 -> after DEPTH+1 advancing cycles: m_dest=2, magnitude about 823 (within 2), phase about 0.
REQ-043 Channel 1, I=0, Q=1000 -> m_dest=1, phase about 2^30 (within 16) for WIDTH=32.
REQ-044 All four channels continuously valid, enable=4'b1111 -> grants 0,1,2,3,0,... with one issue per cycle; m_dest sequence matches issue order.
REQ-045 enable=4'b1011 with all channels valid -> channel 2 is never granted; grant order is 0,1,3,0,...
REQ-046 m_ready held low for 50 cycles mid-stream -> no issue; inflight constant; on release, results resume in order with no lost or duplicated tags.
REQ-047 Core result injected with the tag FIFO empty -> err=1, m_dest=0; err remains 1 until reset, then clears to 0.

Source files
------------

// File: rtl/cordic_scheduler.sv
// Round-robin front end for a shared cartesian-to-polar core: arbitrates channel
// samples into the core and tags each result with its originating channel.
module cordic_scheduler #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int CHANNELS = 4,
  parameter int TAGS     = 32,
  localparam int CW      = $clog2(CHANNELS),
  localparam int TW      = $clog2(TAGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          enable,
  input  logic [CHANNELS-1:0]          s_valid,
  output logic [CHANNELS-1:0]          s_ready,
  input  logic [CHANNELS*2*WIDTH-1:0]  s_data,
  output logic                         c_s_valid,
  input  logic                         c_s_ready,
  output logic [2*WIDTH-1:0]           c_s_data,
  input  logic                         c_m_valid,
  output logic                         c_m_ready,
  input  logic [2*WIDTH-1:0]           c_m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [2*WIDTH-1:0]           m_data,
  output logic [CW-1:0]                m_dest,
  output logic [TW:0]                  inflight,
  output logic                         err
);

  // The tag FIFO must cover the full core latency plus the issue/delivery overlap.
  if (TAGS < DEPTH + 2 || (TAGS & (TAGS - 1)) != 0 || CHANNELS < 2 || CHANNELS > 16) begin : g_bad_params
    $error("cordic_scheduler: illegal parameter combination");
  end

  logic [CW-1:0]       rr;
  logic [CW-1:0]       grant;
  logic                found;
  logic [CHANNELS-1:0] elig;
  logic                full;
  logic                empty;
  logic                issue;
  logic                pop;
  logic [CW-1:0]       tag_mem [TAGS];
  logic [TW-1:0]       wr_ptr;
  logic [TW-1:0]       rd_ptr;
  logic [TW:0]         count;

  assign elig  = s_valid & enable;
  assign full  = (count == (TW+1)'(TAGS));
  assign empty = (count == '0);

  always_comb begin
    grant = rr;
    found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && elig[(int'(rr) + i) % CHANNELS]) begin
        found = 1'b1;
        grant = CW'((int'(rr) + i) % CHANNELS);
      end
    end
  end

  // Held low during reset so nothing is offered while state is being cleared.
  assign c_s_valid = found && !full && !reset;
  assign c_s_data  = s_data[int'(grant)*2*WIDTH +: 2*WIDTH];
  assign issue     = c_s_valid && c_s_ready;

  always_comb begin
    s_ready = '0;
    if (issue) s_ready[grant] = 1'b1;
  end

  assign m_valid   = c_m_valid;
  assign m_data    = c_m_data;
  assign c_m_ready = m_ready;
  assign pop       = c_m_valid && m_ready && !empty;
  assign m_dest    = empty ? '0 : tag_mem[rd_ptr];
  assign inflight  = count;

  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr     <= (grant == CW'(CHANNELS - 1)) ? '0 : grant + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (issue && !pop)      count <= count + 1'b1;
      else if (pop && !issue) count <= count - 1'b1;
      // A result with no outstanding tag means the core and scheduler disagree.
      if (c_m_valid && empty) err <= 1'b1;
    end
  end

endmodule
